hmmm_loader: RTL and testbench

HMMM_LOADER -- requirements
Module: hmmm_loader

---
 rtl/hmmm_loader.sv | 169 ++++++++++++++++
 tb/tb_hmmm_loader.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hmmm_loader.sv
// Byte-stream program loader: count byte, N big-endian words strobed onto the CPU bus as
// address/data pairs, then a one-cycle CPU reset. HMMM_LOADER_CHECKSUM_EN adds a trailing XOR check.
module hmmm_loader (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [15:0] bus_out,
    output logic        bus_oe,
    output logic        pgrm_addr,
    output logic        pgrm_data,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output logic        err
);

`ifdef HMMM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {StIdle, StHi, StLo, StAddr, StData, StCsum, StRst} state_e;
    localparam state_e StEnd = StCsum;
`else
    typedef enum logic [2:0] {StIdle, StHi, StLo, StAddr, StData, StRst} state_e;
    localparam state_e StEnd = StRst;
`endif

    state_e      r_state, w_state_d;
    logic [7:0]  r_addr, r_n;
    logic [15:0] r_word;
    logic        r_in_ready, r_pgrm_addr, r_pgrm_data, r_cpu_rst, r_busy, r_done;
    logic [15:0] r_bus_out;
    logic        w_in_ready_d, w_pgrm_addr_d, w_pgrm_data_d, w_cpu_rst_d, w_busy_d, w_done_d;
    logic [15:0] w_bus_out_d;
    logic        w_accept, w_last, w_csum_fail;

    assign w_accept = in_valid & r_in_ready;
    assign w_last   = (r_addr + 8'd1) == r_n;

`ifdef HMMM_LOADER_CHECKSUM_EN
    logic [7:0] r_csum;
    logic       r_err;
    assign w_csum_fail = (r_state == StCsum) && w_accept && (in_data != r_csum);
    assign err         = r_err;
`else
    assign w_csum_fail = 1'b0;
    assign err         = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle: if (w_accept) w_state_d = (in_data != 8'd0) ? StHi : StEnd;
            StHi:   if (w_accept) w_state_d = StLo;
            StLo:   if (w_accept) w_state_d = StAddr;
            StAddr: w_state_d = StData;
            StData: w_state_d = w_last ? StEnd : StHi;
`ifdef HMMM_LOADER_CHECKSUM_EN
            StCsum: if (w_accept) w_state_d = w_csum_fail ? StIdle : StRst;
`endif
            StRst:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the upcoming state and registered, so they reset to 0.
    always_comb begin
        w_in_ready_d  = 1'b0;
        w_pgrm_addr_d = 1'b0;
        w_pgrm_data_d = 1'b0;
        w_cpu_rst_d   = 1'b0;
        w_bus_out_d   = 16'h0000;
        case (w_state_d)
            StIdle, StHi, StLo: w_in_ready_d = 1'b1;
`ifdef HMMM_LOADER_CHECKSUM_EN
            StCsum: w_in_ready_d = 1'b1;
`endif
            StAddr: begin
                w_pgrm_addr_d = 1'b1;
                w_bus_out_d   = {8'h00, r_addr};
            end
            StData: begin
                w_pgrm_data_d = 1'b1;
                w_bus_out_d   = r_word;
            end
            StRst: w_cpu_rst_d = 1'b1;
            default: ;
        endcase
        w_busy_d = (w_state_d != StIdle);
        w_done_d = (r_state == StRst) | w_csum_fail;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready  <= 1'b0;
            r_pgrm_addr <= 1'b0;
            r_pgrm_data <= 1'b0;
            r_cpu_rst   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_bus_out   <= 16'h0000;
        end else begin
            r_in_ready  <= w_in_ready_d;
            r_pgrm_addr <= w_pgrm_addr_d;
            r_pgrm_data <= w_pgrm_data_d;
            r_cpu_rst   <= w_cpu_rst_d;
            r_busy      <= w_busy_d;
            r_done      <= w_done_d;
            r_bus_out   <= w_bus_out_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= 8'd0;
            r_n    <= 8'd0;
            r_word <= 16'h0000;
`ifdef HMMM_LOADER_CHECKSUM_EN
            r_csum <= 8'd0;
            r_err  <= 1'b0;
`endif
        end else begin
            case (r_state)
                StIdle: if (w_accept) begin
                    r_n    <= in_data;
                    r_addr <= 8'd0;
`ifdef HMMM_LOADER_CHECKSUM_EN
                    r_csum <= 8'd0;
                    r_err  <= 1'b0;
`endif
                end
                StHi: if (w_accept) begin
                    r_word[15:8] <= in_data;
`ifdef HMMM_LOADER_CHECKSUM_EN
                    r_csum <= r_csum ^ in_data;
`endif
                end
                StLo: if (w_accept) begin
                    r_word[7:0] <= in_data;
`ifdef HMMM_LOADER_CHECKSUM_EN
                    r_csum <= r_csum ^ in_data;
`endif
                end
                StData: r_addr <= r_addr + 8'd1;
`ifdef HMMM_LOADER_CHECKSUM_EN
                StCsum: if (w_csum_fail) r_err <= 1'b1;
`endif
                default: ;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign bus_out   = r_bus_out;
    assign bus_oe    = r_pgrm_addr | r_pgrm_data;
    assign pgrm_addr = r_pgrm_addr;
    assign pgrm_data = r_pgrm_data;
    assign cpu_rst   = r_cpu_rst;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_hmmm_loader.sv
// Bench for hmmm_loader: frame-level model predicts per-cycle outputs; directed frames
// with literal checks on the observed strobe log. Checksum tests need HMMM_LOADER_CHECKSUM_EN.
module tb_hmmm_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [15:0] bus_out;
    logic        bus_oe, pgrm_addr, pgrm_data, cpu_rst, busy, done, err;

    hmmm_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .bus_out   (bus_out),
        .bus_oe    (bus_oe),
        .pgrm_addr (pgrm_addr),
        .pgrm_data (pgrm_data),
        .cpu_rst   (cpu_rst),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    // Expected future cycles, queued when the byte that causes them is accepted.
    typedef struct packed {logic pa; logic pd; logic crst; logic dn; logic [15:0] bus;} ev_t;
    typedef struct packed {logic [1:0] kind; logic [15:0] bus;} lg_t;
    ev_t        exp_q[$];
    lg_t        log_q[$];
    logic [7:0] tx_q[$];

    bit         m_in_frame = 1'b0;
    bit         m_err = 1'b0;
    int         m_idx, m_n;
    logic [7:0] m_hi, m_x;
    int         m_edges = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_edges <= 0;
        else if (m_edges < 3) m_edges <= m_edges + 1;
    end

    task automatic push_end(input bit with_rst);
        if (with_rst) exp_q.push_back('{pa: 1'b0, pd: 1'b0, crst: 1'b1, dn: 1'b0, bus: 16'h0});
        exp_q.push_back('{pa: 1'b0, pd: 1'b0, crst: 1'b0, dn: 1'b1, bus: 16'h0});
        m_in_frame = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (!m_in_frame) begin
            m_n = int'(b); m_idx = 0; m_err = 1'b0; m_x = 8'h00; m_in_frame = 1'b1;
`ifndef HMMM_LOADER_CHECKSUM_EN
            if (m_n == 0) push_end(1'b1);
`endif
        end else if (m_idx < 2 * m_n) begin
            m_idx++;
            m_x = m_x ^ b;
            if (m_idx % 2 == 1) begin
                m_hi = b;
            end else begin
                exp_q.push_back('{pa: 1'b1, pd: 1'b0, crst: 1'b0, dn: 1'b0,
                                  bus: 16'(m_idx / 2 - 1)});
                exp_q.push_back('{pa: 1'b0, pd: 1'b1, crst: 1'b0, dn: 1'b0, bus: {m_hi, b}});
`ifndef HMMM_LOADER_CHECKSUM_EN
                if (m_idx == 2 * m_n) push_end(1'b1);
`endif
            end
        end else begin
            if (b == m_x) begin
                push_end(1'b1);
            end else begin
                m_err = 1'b1;
                push_end(1'b0);
            end
        end
    endtask

    always @(negedge clk) begin
        ev_t        e;
        logic       ir, bz;
        if (!rst_n) begin
            chk("reset_outputs", {8'h00, in_ready, bus_out, bus_oe, pgrm_addr, pgrm_data,
                cpu_rst, busy, done, err}, 32'h0);
            exp_q.delete();
            m_in_frame = 1'b0;
            m_err = 1'b0;
        end else begin
            e  = '0;
            ir = (m_edges != 0);
            bz = m_in_frame;
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                ir = e.dn && (m_edges != 0);
                bz = !e.dn;
            end
            chk("cycle_outputs",
                {8'h00, in_ready, bus_out, bus_oe, pgrm_addr, pgrm_data, cpu_rst, busy, done, err},
                {8'h00, ir, e.bus, e.pa | e.pd, e.pa, e.pd, e.crst, bz, e.dn, m_err});
            if (pgrm_addr) log_q.push_back('{kind: 2'd1, bus: bus_out});
            if (pgrm_data) log_q.push_back('{kind: 2'd2, bus: bus_out});
            if (cpu_rst)   log_q.push_back('{kind: 2'd3, bus: 16'h0});
            if (in_valid && in_ready) model_byte(in_data);
        end
    end

    task automatic put(input logic [7:0] b);
        int k;
        in_valid = 1'b1;
        in_data  = b;
        k = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            k++;
            if (k > 50) begin
                chk("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit hold);
`ifdef HMMM_LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
        for (int i = 1; i < tx_q.size(); i++) x = x ^ tx_q[i];
        tx_q.push_back(x);
`endif
        foreach (tx_q[i]) begin
            put(tx_q[i]);
            if (!hold) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
        tx_q.delete();
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        forever begin
            @(negedge clk);
            if (done) break;
            k++;
            if (k > 100) begin
                chk("done_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_log(input int idx, input logic [1:0] kind, input logic [15:0] bus);
        if (idx < log_q.size()) chk($sformatf("log[%0d]", idx), 32'(log_q[idx]), 32'({kind, bus}));
        else chk($sformatf("log[%0d]_missing", idx), 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_ready_busy", {30'd0, in_ready, busy}, {30'd0, 1'b1, 1'b0});

        // Three-word frame, bytes spaced by idle cycles.
        log_q.delete();
        tx_q = '{8'h03, 8'h01, 8'h01, 8'h01, 8'h02, 8'h00, 8'h00};
        send(1'b0);
        wait_done();
        chk("frame3_log_size", 32'(log_q.size()), 32'd7);
        chk_log(0, 2'd1, 16'h0000); chk_log(1, 2'd2, 16'h0101);
        chk_log(2, 2'd1, 16'h0001); chk_log(3, 2'd2, 16'h0102);
        chk_log(4, 2'd1, 16'h0002); chk_log(5, 2'd2, 16'h0000);
        chk_log(6, 2'd3, 16'h0000);

        // Empty frame.
        log_q.delete();
`ifndef HMMM_LOADER_CHECKSUM_EN
        put(8'h00);
        in_valid = 1'b0;
        chk("n0_cpu_rst_next", {30'd0, cpu_rst, pgrm_addr}, {30'd0, 1'b1, 1'b0});
        wait_done();
`else
        tx_q = '{8'h00};
        send(1'b0);
        wait_done();
`endif
        chk("n0_log_size", 32'(log_q.size()), 32'd1);
        chk_log(0, 2'd3, 16'h0000);

        // Valid held high throughout.
        log_q.delete();
        tx_q = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44};
        send(1'b1);
        wait_done();
        chk("hold_log_size", 32'(log_q.size()), 32'd5);
        chk_log(0, 2'd1, 16'h0000); chk_log(1, 2'd2, 16'h1122);
        chk_log(2, 2'd1, 16'h0001); chk_log(3, 2'd2, 16'h3344);

        // Five-cycle gap between high and low byte.
        log_q.delete();
        put(8'h01);
        put(8'hAA);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("stall_no_strobes", 32'(log_q.size()), 32'd0);
        chk("stall_busy_ready", {30'd0, busy, in_ready}, {30'd0, 1'b1, 1'b1});
        put(8'hBB);
`ifdef HMMM_LOADER_CHECKSUM_EN
        put(8'h11);
`endif
        in_valid = 1'b0;
        wait_done();
        chk_log(0, 2'd1, 16'h0000); chk_log(1, 2'd2, 16'hAABB);

        // Reset during the DATA cycle of word 1.
        log_q.delete();
        put(8'h03); put(8'h01); put(8'h01); put(8'h01); put(8'h02);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_reset_data", {15'd0, pgrm_data, bus_out}, {15'd0, 1'b1, 16'h0102});
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_zero", {8'h00, in_ready, bus_out, bus_oe, pgrm_addr, pgrm_data,
            cpu_rst, busy, done, err}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_no_cpu_rst", 32'(log_q.size()), 32'd3);
        log_q.delete();
        tx_q = '{8'h01, 8'hAB, 8'hCD};
        send(1'b0);
        wait_done();
        chk_log(0, 2'd1, 16'h0000); chk_log(1, 2'd2, 16'hABCD); chk_log(2, 2'd3, 16'h0000);

`ifdef HMMM_LOADER_CHECKSUM_EN
        // Good checksum.
        log_q.delete();
        put(8'h01); put(8'h12); put(8'h34); put(8'h26);
        in_valid = 1'b0;
        wait_done();
        chk("csum_ok_err", {31'd0, err}, 32'd0);
        chk_log(2, 2'd3, 16'h0000);
        // Bad checksum: done without cpu_rst, err sticks until next count byte.
        log_q.delete();
        put(8'h01); put(8'h12); put(8'h34); put(8'h00);
        in_valid = 1'b0;
        wait_done();
        repeat (3) @(posedge clk);
        #1;
        chk("csum_bad_err_hold", {31'd0, err}, 32'd1);
        chk("csum_bad_no_rst", 32'(log_q.size()), 32'd2);
        put(8'h00);
        in_valid = 1'b0;
        chk("csum_err_cleared", {31'd0, err}, 32'd0);
        put(8'h00);
        in_valid = 1'b0;
        wait_done();
`endif

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
